// File: rtl/xphy_pkg.sv
// Shared definitions for the multi-channel XGMII link controller:
// idle pattern, link FSM encoding and the forced-idle helper.
package xphy_pkg;

  localparam logic [63:0] XGMII_IDLE_D = 64'h0707070707070707;
  localparam logic [7:0]  XGMII_IDLE_C = 8'hFF;
  localparam int unsigned DROP_CNT_W   = 8;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_WAIT  = 2'd1,
    ST_QUAL  = 2'd2,
    ST_UP    = 2'd3
  } link_state_e;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  c;
  } xgmii_t;

  function automatic xgmii_t xgmii_gate(input logic pass, input xgmii_t x);
    xgmii_t idle;
    idle.d = XGMII_IDLE_D;
    idle.c = XGMII_IDLE_C;
    return pass ? x : idle;
  endfunction

endpackage

// File: rtl/xphy_link_ch.sv
// One XGMII channel: status synchronisers, link qualification FSM,
// saturating drop counter and the forced-idle XGMII pipes.
module xphy_link_ch
  import xphy_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned DEBOUNCE_BITS = 4,
  parameter int unsigned PIPE          = 1
) (
  input  logic                  clk156,
  input  logic                  reset,
  input  logic                  tx_resetdone_i,
  input  logic                  rx_resetdone_i,
  input  logic                  tx_fault_i,
  input  logic                  signal_detect_i,
  input  logic [63:0]           xgmii_txd_i,
  input  logic [7:0]            xgmii_txc_i,
  input  logic [63:0]           xgmii_rxd_int_i,
  input  logic [7:0]            xgmii_rxc_int_i,
  output logic [63:0]           xgmii_txd_int_o,
  output logic [7:0]            xgmii_txc_int_o,
  output logic [63:0]           xgmii_rxd_o,
  output logic [7:0]            xgmii_rxc_o,
  output logic                  core_reset_tx_o,
  output logic                  core_reset_rx_o,
  output logic                  link_up_o,
  output logic                  resetdone_o,
  output logic [DROP_CNT_W-1:0] link_drop_cnt_o
);

  logic [SYNC_STAGES-1:0] txrd_sync_q;
  logic [SYNC_STAGES-1:0] rxrd_sync_q;
  logic [SYNC_STAGES-1:0] fault_sync_q;
  logic [SYNC_STAGES-1:0] sd_sync_q;
  logic                   good;

  // Reset values make the channel read as bad until real status arrives.
  always_ff @(posedge clk156 or posedge reset) begin
    if (reset) begin
      txrd_sync_q  <= '0;
      rxrd_sync_q  <= '0;
      fault_sync_q <= '1;
      sd_sync_q    <= '0;
    end else begin
      txrd_sync_q  <= {txrd_sync_q[SYNC_STAGES-2:0], tx_resetdone_i};
      rxrd_sync_q  <= {rxrd_sync_q[SYNC_STAGES-2:0], rx_resetdone_i};
      fault_sync_q <= {fault_sync_q[SYNC_STAGES-2:0], tx_fault_i};
      sd_sync_q    <= {sd_sync_q[SYNC_STAGES-2:0], signal_detect_i};
    end
  end

  assign good = txrd_sync_q[SYNC_STAGES-1] & rxrd_sync_q[SYNC_STAGES-1] &
                ~fault_sync_q[SYNC_STAGES-1] & sd_sync_q[SYNC_STAGES-1];
  assign resetdone_o = txrd_sync_q[SYNC_STAGES-1] & rxrd_sync_q[SYNC_STAGES-1];

  link_state_e              state_q, state_d;
  logic [DEBOUNCE_BITS-1:0] cnt_q, cnt_d;
  logic [DROP_CNT_W-1:0]    drop_q, drop_d;
  logic                     core_reset_tx_q, core_reset_rx_q, link_up_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drop_d  = drop_q;
    unique case (state_q)
      ST_RESET: state_d = ST_WAIT;
      ST_WAIT: begin
        if (good) begin
          state_d = ST_QUAL;
          cnt_d   = '0;
        end
      end
      ST_QUAL: begin
        if (!good) begin
          state_d = ST_WAIT;
        end else if (cnt_q == '1) begin
          state_d = ST_UP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_UP: begin
        if (!good) begin
          state_d = ST_WAIT;
          if (drop_q != '1) begin
            drop_d = drop_q + 1'b1;
          end
        end
      end
    endcase
  end

  // Outputs are registered from the next state so they align with state_q.
  always_ff @(posedge clk156 or posedge reset) begin
    if (reset) begin
      state_q         <= ST_RESET;
      cnt_q           <= '0;
      drop_q          <= '0;
      core_reset_tx_q <= 1'b1;
      core_reset_rx_q <= 1'b1;
      link_up_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      drop_q          <= drop_d;
      core_reset_tx_q <= (state_d == ST_RESET) || (state_d == ST_WAIT);
      core_reset_rx_q <= (state_d != ST_UP);
      link_up_q       <= (state_d == ST_UP);
    end
  end

  assign core_reset_tx_o = core_reset_tx_q;
  assign core_reset_rx_o = core_reset_rx_q;
  assign link_up_o       = link_up_q;
  assign link_drop_cnt_o = drop_q;

  xgmii_t tx_pipe_q [PIPE];
  xgmii_t rx_pipe_q [PIPE];
  xgmii_t idle_word;

  assign idle_word.d = XGMII_IDLE_D;
  assign idle_word.c = XGMII_IDLE_C;

  always_ff @(posedge clk156 or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < PIPE; i++) begin
        tx_pipe_q[i] <= idle_word;
        rx_pipe_q[i] <= idle_word;
      end
    end else begin
      tx_pipe_q[0] <= xgmii_gate(link_up_q, {xgmii_txd_i, xgmii_txc_i});
      rx_pipe_q[0] <= xgmii_gate(link_up_q, {xgmii_rxd_int_i, xgmii_rxc_int_i});
      for (int unsigned i = 1; i < PIPE; i++) begin
        tx_pipe_q[i] <= tx_pipe_q[i-1];
        rx_pipe_q[i] <= rx_pipe_q[i-1];
      end
    end
  end

  assign xgmii_txd_int_o = tx_pipe_q[PIPE-1].d;
  assign xgmii_txc_int_o = tx_pipe_q[PIPE-1].c;
  assign xgmii_rxd_o     = rx_pipe_q[PIPE-1].d;
  assign xgmii_rxc_o     = rx_pipe_q[PIPE-1].c;

endmodule

// File: rtl/xphy_link_ctrl.sv
// Multi-channel 10G PHY glue: replicates the per-channel link controller
// and combines the transceiver reset-done status.
module xphy_link_ctrl
  import xphy_pkg::*;
#(
  parameter int unsigned C_NUM_CH        = 1,
  parameter int unsigned C_SYNC_STAGES   = 2,
  parameter int unsigned C_DEBOUNCE_BITS = 4,
  parameter int unsigned C_PIPE          = 1,
  parameter logic [4:0]  C_MDIO_ADDR     = 5'h0
) (
  input  logic                           clk156,
  input  logic                           reset,
  input  logic [C_NUM_CH-1:0]            tx_resetdone,
  input  logic [C_NUM_CH-1:0]            rx_resetdone,
  input  logic [C_NUM_CH-1:0]            tx_fault,
  input  logic [C_NUM_CH-1:0]            signal_detect,
  input  logic [64*C_NUM_CH-1:0]         xgmii_txd,
  input  logic [8*C_NUM_CH-1:0]          xgmii_txc,
  input  logic [64*C_NUM_CH-1:0]         xgmii_rxd_int,
  input  logic [8*C_NUM_CH-1:0]          xgmii_rxc_int,
  output logic [64*C_NUM_CH-1:0]         xgmii_txd_int,
  output logic [8*C_NUM_CH-1:0]          xgmii_txc_int,
  output logic [64*C_NUM_CH-1:0]         xgmii_rxd,
  output logic [8*C_NUM_CH-1:0]          xgmii_rxc,
  output logic [C_NUM_CH-1:0]            core_reset_tx,
  output logic [C_NUM_CH-1:0]            core_reset_rx,
  output logic [C_NUM_CH-1:0]            link_up,
  output logic                           resetdone,
  output logic [DROP_CNT_W*C_NUM_CH-1:0] link_drop_cnt,
  output logic [5*C_NUM_CH-1:0]          prtad
);

  logic [C_NUM_CH-1:0] ch_resetdone;

  for (genvar i = 0; i < C_NUM_CH; i++) begin : g_ch
    xphy_link_ch #(
      .SYNC_STAGES  (C_SYNC_STAGES),
      .DEBOUNCE_BITS(C_DEBOUNCE_BITS),
      .PIPE         (C_PIPE)
    ) u_ch (
      .clk156          (clk156),
      .reset           (reset),
      .tx_resetdone_i  (tx_resetdone[i]),
      .rx_resetdone_i  (rx_resetdone[i]),
      .tx_fault_i      (tx_fault[i]),
      .signal_detect_i (signal_detect[i]),
      .xgmii_txd_i     (xgmii_txd[i*64 +: 64]),
      .xgmii_txc_i     (xgmii_txc[i*8 +: 8]),
      .xgmii_rxd_int_i (xgmii_rxd_int[i*64 +: 64]),
      .xgmii_rxc_int_i (xgmii_rxc_int[i*8 +: 8]),
      .xgmii_txd_int_o (xgmii_txd_int[i*64 +: 64]),
      .xgmii_txc_int_o (xgmii_txc_int[i*8 +: 8]),
      .xgmii_rxd_o     (xgmii_rxd[i*64 +: 64]),
      .xgmii_rxc_o     (xgmii_rxc[i*8 +: 8]),
      .core_reset_tx_o (core_reset_tx[i]),
      .core_reset_rx_o (core_reset_rx[i]),
      .link_up_o       (link_up[i]),
      .resetdone_o     (ch_resetdone[i]),
      .link_drop_cnt_o (link_drop_cnt[i*DROP_CNT_W +: DROP_CNT_W])
    );

    // 5-bit add wraps the MDIO address modulo 32.
    assign prtad[i*5 +: 5] = C_MDIO_ADDR + 5'(i);
  end

  assign resetdone = &ch_resetdone;

endmodule

// File: tb/tb_xphy_link_ctrl.sv
// Randomised bench for xphy_link_ctrl: a run-length link model feeds a
// scoreboard queue that a monitor drains every cycle.
module tb_xphy_link_ctrl;

  localparam int N        = 2;
  localparam int SYNC     = 2;
  localparam int DB       = 4;
  localparam int PIPE     = 2;
  localparam logic [4:0] MDIO = 5'd31;
  localparam int QUAL_RUN = (1 << DB) + 1;   // consecutive good edges from WAIT to UP
  localparam logic [71:0] IDLE = {64'h0707070707070707, 8'hFF};

  logic             clk156 = 1'b0;
  logic             reset  = 1'b1;
  logic [N-1:0]     tx_resetdone = '0, rx_resetdone = '0, tx_fault = '1, signal_detect = '0;
  logic [64*N-1:0]  xgmii_txd = '0, xgmii_rxd_int = '0;
  logic [8*N-1:0]   xgmii_txc = '0, xgmii_rxc_int = '0;
  logic [64*N-1:0]  xgmii_txd_int, xgmii_rxd;
  logic [8*N-1:0]   xgmii_txc_int, xgmii_rxc;
  logic [N-1:0]     core_reset_tx, core_reset_rx, link_up;
  logic             resetdone;
  logic [8*N-1:0]   link_drop_cnt;
  logic [5*N-1:0]   prtad;

  always #5 clk156 = ~clk156;

  xphy_link_ctrl #(
    .C_NUM_CH(N), .C_SYNC_STAGES(SYNC), .C_DEBOUNCE_BITS(DB),
    .C_PIPE(PIPE), .C_MDIO_ADDR(MDIO)
  ) dut (
    .clk156(clk156), .reset(reset),
    .tx_resetdone(tx_resetdone), .rx_resetdone(rx_resetdone),
    .tx_fault(tx_fault), .signal_detect(signal_detect),
    .xgmii_txd(xgmii_txd), .xgmii_txc(xgmii_txc),
    .xgmii_rxd_int(xgmii_rxd_int), .xgmii_rxc_int(xgmii_rxc_int),
    .xgmii_txd_int(xgmii_txd_int), .xgmii_txc_int(xgmii_txc_int),
    .xgmii_rxd(xgmii_rxd), .xgmii_rxc(xgmii_rxc),
    .core_reset_tx(core_reset_tx), .core_reset_rx(core_reset_rx),
    .link_up(link_up), .resetdone(resetdone),
    .link_drop_cnt(link_drop_cnt), .prtad(prtad)
  );

  int errors = 0;
  int checks = 0;

  function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  typedef struct {
    logic [N-1:0]    crt, crr, lu;
    logic [8*N-1:0]  drops;
    logic            rd;
    logic [64*N-1:0] txd, rxd;
    logic [8*N-1:0]  txc, rxc;
  } exp_t;

  exp_t sb[$];

  bit [SYNC-1:0] m_txrd[N], m_rxrd[N], m_flt[N], m_sd[N];
  bit            m_started[N];
  int            m_run[N];
  bit            m_up[N];
  int            m_drops[N];
  logic [71:0]   m_txp[N][PIPE], m_rxp[N][PIPE];

  function automatic void model_reset();
    for (int ch = 0; ch < N; ch++) begin
      m_txrd[ch] = '0; m_rxrd[ch] = '0; m_flt[ch] = '1; m_sd[ch] = '0;
      m_started[ch] = 0; m_run[ch] = 0; m_up[ch] = 0; m_drops[ch] = 0;
      for (int k = 0; k < PIPE; k++) begin
        m_txp[ch][k] = IDLE;
        m_rxp[ch][k] = IDLE;
      end
    end
  endfunction

  function automatic void model_step();
    for (int ch = 0; ch < N; ch++) begin
      bit gs, up_pre;
      gs = m_txrd[ch][SYNC-1] & m_rxrd[ch][SYNC-1] & ~m_flt[ch][SYNC-1] & m_sd[ch][SYNC-1];
      up_pre = m_up[ch];
      for (int k = PIPE - 1; k > 0; k--) begin
        m_txp[ch][k] = m_txp[ch][k-1];
        m_rxp[ch][k] = m_rxp[ch][k-1];
      end
      m_txp[ch][0] = up_pre ? {xgmii_txd[ch*64 +: 64], xgmii_txc[ch*8 +: 8]} : IDLE;
      m_rxp[ch][0] = up_pre ? {xgmii_rxd_int[ch*64 +: 64], xgmii_rxc_int[ch*8 +: 8]} : IDLE;
      if (!m_started[ch]) begin
        m_started[ch] = 1;
      end else if (!gs) begin
        if (m_up[ch] && m_drops[ch] < 255) m_drops[ch]++;
        m_up[ch]  = 0;
        m_run[ch] = 0;
      end else begin
        if (m_run[ch] < QUAL_RUN) m_run[ch]++;
        if (m_run[ch] == QUAL_RUN) m_up[ch] = 1;
      end
      m_txrd[ch] = {m_txrd[ch][SYNC-2:0], tx_resetdone[ch]};
      m_rxrd[ch] = {m_rxrd[ch][SYNC-2:0], rx_resetdone[ch]};
      m_flt[ch]  = {m_flt[ch][SYNC-2:0], tx_fault[ch]};
      m_sd[ch]   = {m_sd[ch][SYNC-2:0], signal_detect[ch]};
    end
  endfunction

  initial model_reset();
  always @(posedge reset) model_reset();

  always @(posedge clk156) begin : model_proc
    exp_t e;
    if (reset) model_reset();
    else model_step();
    e.rd = 1'b1;
    for (int ch = 0; ch < N; ch++) begin
      e.crt[ch] = (m_run[ch] == 0);
      e.crr[ch] = !m_up[ch];
      e.lu[ch]  = m_up[ch];
      e.drops[ch*8 +: 8] = 8'(m_drops[ch]);
      e.rd = e.rd & m_txrd[ch][SYNC-1] & m_rxrd[ch][SYNC-1];
      {e.txd[ch*64 +: 64], e.txc[ch*8 +: 8]} = m_txp[ch][PIPE-1];
      {e.rxd[ch*64 +: 64], e.rxc[ch*8 +: 8]} = m_rxp[ch][PIPE-1];
    end
    sb.push_back(e);
  end

  // ---------------- monitor ----------------
  always @(posedge clk156) begin : monitor_proc
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("core_reset_tx", 128'(core_reset_tx), 128'(e.crt));
      chk("core_reset_rx", 128'(core_reset_rx), 128'(e.crr));
      chk("link_up",       128'(link_up),       128'(e.lu));
      chk("link_drop_cnt", 128'(link_drop_cnt), 128'(e.drops));
      chk("resetdone",     128'(resetdone),     128'(e.rd));
      chk("xgmii_txd_int", 128'(xgmii_txd_int), 128'(e.txd));
      chk("xgmii_txc_int", 128'(xgmii_txc_int), 128'(e.txc));
      chk("xgmii_rxd",     128'(xgmii_rxd),     128'(e.rxd));
      chk("xgmii_rxc",     128'(xgmii_rxc),     128'(e.rxc));
    end
  end

  // ---------------- data driver ----------------
  bit          count_mode = 0;
  int unsigned dcnt = 0;

  initial begin
    forever begin
      @(negedge clk156);
      dcnt++;
      for (int ch = 0; ch < N; ch++) begin
        if (count_mode) begin
          xgmii_txd[ch*64 +: 64]     = {32'(dcnt), 32'(ch)};
          xgmii_rxd_int[ch*64 +: 64] = {32'(~dcnt), 32'(ch + 8)};
          xgmii_txc[ch*8 +: 8]       = 8'(dcnt);
          xgmii_rxc_int[ch*8 +: 8]   = 8'(dcnt + 3);
        end else begin
          xgmii_txd[ch*64 +: 64]     = {$urandom, $urandom};
          xgmii_rxd_int[ch*64 +: 64] = {$urandom, $urandom};
          xgmii_txc[ch*8 +: 8]       = 8'($urandom);
          xgmii_rxc_int[ch*8 +: 8]   = 8'($urandom);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [5*N-1:0] exp_prtad();
    logic [5*N-1:0] p;
    for (int ch = 0; ch < N; ch++) p[ch*5 +: 5] = 5'((int'(MDIO) + ch) % 32);
    return p;
  endfunction

  task automatic all_good();
    tx_resetdone = '1; rx_resetdone = '1; tx_fault = '0; signal_detect = '1;
  endtask

  // Asynchronous reset between edges; the reset values must appear at once.
  task automatic do_reset();
    @(negedge clk156);
    #2 reset = 1'b1;
    #1;
    chk("rst_core_reset_tx", 128'(core_reset_tx), 128'({N{1'b1}}));
    chk("rst_core_reset_rx", 128'(core_reset_rx), 128'({N{1'b1}}));
    chk("rst_link_up",       128'(link_up),       128'(0));
    chk("rst_drop_cnt",      128'(link_drop_cnt), 128'(0));
    chk("rst_txd_int",       128'(xgmii_txd_int), 128'({N{IDLE[71:8]}}));
    chk("rst_prtad",         128'(prtad),         128'(exp_prtad()));
    repeat (2) @(negedge clk156);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int tx_fall, rx_fall;
    repeat (3) @(negedge clk156);
    chk("prtad", 128'(prtad), 128'(exp_prtad()));

    // Bring-up with fixed latency checks.
    all_good();
    reset = 1'b0;
    tx_fall = 0; rx_fall = 0;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      @(posedge clk156); #1;
      if (tx_fall == 0 && !core_reset_tx[0]) tx_fall = cyc;
      if (!core_reset_rx[0]) begin rx_fall = cyc; break; end
    end
    chk("bringup_tx_release", 128'(tx_fall), 128'(SYNC + 1));
    chk("bringup_link_up",    128'(rx_fall), 128'(SYNC + 1 + (1 << DB)));
    chk("bringup_both_up",    128'(link_up), 128'({N{1'b1}}));
    @(negedge clk156);
    count_mode = 1;
    repeat (20) @(negedge clk156);
    count_mode = 0;

    // Single-cycle signal_detect glitch on channel 0 swept across QUAL,
    // including the cycle where the debounce counter hits its maximum.
    for (int off = 8; off <= 24; off++) begin
      do_reset();
      all_good();
      reset = 1'b0;
      repeat (off) @(negedge clk156);
      signal_detect[0] = 1'b0;
      @(negedge clk156);
      signal_detect[0] = 1'b1;
      repeat (40) @(negedge clk156);
    end

    // Repeated tx_fault drops on channel 1 drive its counter into saturation.
    do_reset();
    all_good();
    reset = 1'b0;
    count_mode = 1;
    for (int i = 0; i < 300; i++) begin
      repeat (20 + $urandom_range(0, 4)) @(negedge clk156);
      tx_fault[1] = 1'b1;
      repeat ($urandom_range(1, 3)) @(negedge clk156);
      tx_fault[1] = 1'b0;
    end
    count_mode = 0;
    repeat (25) @(negedge clk156);
    chk("drop_cnt_sat_ch1", 128'(link_drop_cnt[15:8]), 128'(255));
    chk("drop_cnt_ch0",     128'(link_drop_cnt[7:0]),  128'(0));
    chk("prtad_mid",        128'(prtad),               128'(exp_prtad()));

    // Random status noise, with the noise level changing per segment.
    for (int seg = 0; seg < 60; seg++) begin
      int noise;
      noise = (seg % 4 == 0) ? 0 : int'($urandom_range(0, 6));
      repeat (40) begin
        @(negedge clk156);
        for (int ch = 0; ch < N; ch++) begin
          tx_resetdone[ch]  = ($urandom_range(0, 99) >= noise);
          rx_resetdone[ch]  = ($urandom_range(0, 99) >= noise);
          tx_fault[ch]      = ($urandom_range(0, 99) < noise);
          signal_detect[ch] = ($urandom_range(0, 99) >= noise);
        end
      end
    end

    // Final reset taken from the UP state.
    @(negedge clk156);
    all_good();
    repeat (30) @(negedge clk156);
    chk("pre_reset_up", 128'(link_up), 128'({N{1'b1}}));
    do_reset();
    repeat (3) @(negedge clk156);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
